// File: rtl/dht11_sensor_emu_pkg.sv
// dht11_pkg: shared types and helpers for the DHT11 sensor emulator and the
// host-side poller.
//   dht11_state_t  - responder FSM states
//   DEF_*          - default protocol timing (us) and clock prescale
//   dht11_checksum - 8-bit wrap-around sum of the four payload bytes
package dht11_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START_LOW,
        RESP_DELAY,
        RESP_LOW,
        RESP_HIGH,
        BIT_LOW,
        BIT_HIGH,
        END_LOW
    } dht11_state_t;

    localparam int DEF_CLK_PER_US    = 27;
    localparam int DEF_START_MIN_US  = 18000;
    localparam int DEF_RESP_DELAY_US = 30;
    localparam int DEF_RESP_LOW_US   = 80;
    localparam int DEF_RESP_HIGH_US  = 80;
    localparam int DEF_BIT_LOW_US    = 50;
    localparam int DEF_BIT0_HIGH_US  = 26;
    localparam int DEF_BIT1_HIGH_US  = 70;

    function automatic logic [7:0] dht11_checksum(input logic [7:0] b0, input logic [7:0] b1,
                                                  input logic [7:0] b2, input logic [7:0] b3);
        return b0 + b1 + b2 + b3;
    endfunction

endpackage

// File: rtl/dht11_sensor_emu_if.sv
// Register-side bundle of the DHT11 emulator.
//   humi_int/humi_dec/temp_int/temp_dec - payload bytes (master -> slave)
//   bad_crc    - invert the transmitted checksum (master -> slave)
//   busy       - frame in progress (slave -> master)
//   frame_done - one-clock pulse at end-pulse release (slave -> master)
//   collision  - one-clock pulse when the line is held low while released
interface dht11_sensor_emu_if;
    logic [7:0] humi_int;
    logic [7:0] humi_dec;
    logic [7:0] temp_int;
    logic [7:0] temp_dec;
    logic       bad_crc;
    logic       busy;
    logic       frame_done;
    logic       collision;

    modport master (output humi_int, humi_dec, temp_int, temp_dec, bad_crc,
                    input  busy, frame_done, collision);
    modport slave  (input  humi_int, humi_dec, temp_int, temp_dec, bad_crc,
                    output busy, frame_done, collision);
endinterface

// File: rtl/dht11_sensor_emu_us_tick.sv
// dht11_us_tick: 1 us tick prescaler.
//   clk, rst_n - system clock, async active-low reset
//   restart    - synchronous restart; counter returns to 0 on the next clock
//   tick       - one-clock pulse every CLK_PER_US clocks
module dht11_us_tick #(
    parameter int CLK_PER_US = 27
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);
    logic [7:0] cnt;

    assign tick = (cnt == 8'(CLK_PER_US - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              cnt <= 8'd0;
        else if (restart || tick) cnt <= 8'd0;
        else                     cnt <= cnt + 8'd1;
    end
endmodule

// File: rtl/dht11_sensor_emu.sv
// dht11_sensor_emu: responder end of the DHT11 single-wire protocol.
//   clk, rst_n - system clock, async active-low reset
//   dht11      - open-drain line, driven 0 or released (z) only
//   bus        - payload bytes / bad_crc in, busy / frame_done / collision out
//
// state      | meaning
// IDLE       | line released, waiting for host falling edge
// START_LOW  | host holding line low, measuring its length
// RESP_DELAY | released, waiting before the response
// RESP_LOW   | driving response low
// RESP_HIGH  | released, response high (collision watched)
// BIT_LOW    | driving bit lead-in / low
// BIT_HIGH   | released, high width encodes the bit (collision watched)
// END_LOW    | driving end pulse
module dht11_sensor_emu
    import dht11_pkg::*;
#(
    parameter int CLK_PER_US    = DEF_CLK_PER_US,
    parameter int START_MIN_US  = DEF_START_MIN_US,
    parameter int RESP_DELAY_US = DEF_RESP_DELAY_US,
    parameter int RESP_LOW_US   = DEF_RESP_LOW_US,
    parameter int RESP_HIGH_US  = DEF_RESP_HIGH_US,
    parameter int BIT_LOW_US    = DEF_BIT_LOW_US,
    parameter int BIT0_HIGH_US  = DEF_BIT0_HIGH_US,
    parameter int BIT1_HIGH_US  = DEF_BIT1_HIGH_US
) (
    input  logic                     clk,
    input  logic                     rst_n,
    inout  wire                      dht11,
    dht11_sensor_emu_if.slave        bus
);
    dht11_state_t state, state_next;
    logic         sync1, sync2, sync_d;
    logic         rise, fall;
    logic         tick, restart;
    logic [15:0]  phase_cnt;
    logic [1:0]   settle;
    logic         watch;
    logic [39:0]  frame;
    logic [5:0]   bit_idx;
    logic         drive_low;
    logic         coll_evt, done_evt;
    logic [15:0]  bit_high_last;

    assign drive_low = (state == RESP_LOW) || (state == BIT_LOW) || (state == END_LOW);
    assign dht11     = drive_low ? 1'b0 : 1'bz;
    assign bus.busy  = (state != IDLE) && (state != START_LOW);

    assign rise    = sync2 & ~sync_d;
    assign fall    = ~sync2 & sync_d;
    assign restart = (state_next != state);

    // The line only reads back high two clocks after release; with a very
    // short tick the first tick alone does not cover that, so also wait for
    // the synchronizer to settle.
    assign watch = (phase_cnt != 16'd0) && (settle == 2'd2);

    assign bit_high_last = frame[bit_idx] ? 16'(BIT1_HIGH_US - 1) : 16'(BIT0_HIGH_US - 1);

    dht11_us_tick #(.CLK_PER_US(CLK_PER_US)) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (restart),
        .tick    (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            sync_d <= 1'b1;
        end else begin
            sync1 <= dht11;
            sync2 <= sync1;
            sync_d <= sync2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        coll_evt   = 1'b0;
        done_evt   = 1'b0;
        case (state)
            IDLE:       if (fall) state_next = START_LOW;
            START_LOW:  if (rise) state_next = (phase_cnt >= 16'(START_MIN_US)) ? RESP_DELAY : IDLE;
            RESP_DELAY: if (tick && phase_cnt == 16'(RESP_DELAY_US - 1)) state_next = RESP_LOW;
            RESP_LOW:   if (tick && phase_cnt == 16'(RESP_LOW_US - 1)) state_next = RESP_HIGH;
            RESP_HIGH: begin
                if (watch && !sync2) begin
                    coll_evt   = 1'b1;
                    state_next = IDLE;
                end else if (tick && phase_cnt == 16'(RESP_HIGH_US - 1)) begin
                    state_next = BIT_LOW;
                end
            end
            BIT_LOW:    if (tick && phase_cnt == 16'(BIT_LOW_US - 1)) state_next = BIT_HIGH;
            BIT_HIGH: begin
                if (watch && !sync2) begin
                    coll_evt   = 1'b1;
                    state_next = IDLE;
                end else if (tick && phase_cnt == bit_high_last) begin
                    state_next = (bit_idx == 6'd0) ? END_LOW : BIT_LOW;
                end
            end
            END_LOW: begin
                if (tick && phase_cnt == 16'(BIT_LOW_US - 1)) begin
                    done_evt   = 1'b1;
                    state_next = IDLE;
                end
            end
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_cnt      <= 16'd0;
            settle         <= 2'd0;
            frame          <= 40'd0;
            bit_idx        <= 6'd0;
            bus.frame_done <= 1'b0;
            bus.collision  <= 1'b0;
        end else begin
            bus.frame_done <= done_evt;
            bus.collision  <= coll_evt;
            if (restart) begin
                phase_cnt <= 16'd0;
                settle    <= 2'd0;
            end else begin
                if (tick && phase_cnt != 16'hFFFF) phase_cnt <= phase_cnt + 16'd1;
                if (settle != 2'd2)                settle    <= settle + 2'd1;
            end
            if (state_next == RESP_DELAY && state != RESP_DELAY)
                frame <= {bus.humi_int, bus.humi_dec, bus.temp_int, bus.temp_dec,
                          dht11_checksum(bus.humi_int, bus.humi_dec, bus.temp_int, bus.temp_dec)
                          ^ {8{bus.bad_crc}}};
            if (state == RESP_HIGH && state_next == BIT_LOW)
                bit_idx <= 6'd39;
            else if (state == BIT_HIGH && state_next == BIT_LOW)
                bit_idx <= bit_idx - 6'd1;
        end
    end
endmodule

// File: tb/tb_dht11_sensor_emu.sv
// Testbench for dht11_sensor_emu: a behavioural host poller drives start
// pulses, measures every phase width in clocks and decodes the 40-bit frame.
// Three instances cover CLK_PER_US = 1, 2 and 27.
module tb_dht11_sensor_emu;
    localparam int START_MIN = 200;
    localparam int START_US  = 220;

    logic       clk;
    logic       rst_n;
    logic [2:0] host_low;
    logic [7:0] humi_int, humi_dec, temp_int, temp_dec;
    logic       bad_crc;
    int         n_assert;
    int         n_fail;

    wire line0, line1, line2;
    assign line0 = host_low[0] ? 1'b0 : 1'bz;
    assign line1 = host_low[1] ? 1'b0 : 1'bz;
    assign line2 = host_low[2] ? 1'b0 : 1'bz;
    pullup (line0);
    pullup (line1);
    pullup (line2);

    dht11_sensor_emu_if if0 ();
    dht11_sensor_emu_if if1 ();
    dht11_sensor_emu_if if2 ();

    assign if0.humi_int = humi_int; assign if0.humi_dec = humi_dec;
    assign if0.temp_int = temp_int; assign if0.temp_dec = temp_dec;
    assign if0.bad_crc  = bad_crc;
    assign if1.humi_int = humi_int; assign if1.humi_dec = humi_dec;
    assign if1.temp_int = temp_int; assign if1.temp_dec = temp_dec;
    assign if1.bad_crc  = bad_crc;
    assign if2.humi_int = humi_int; assign if2.humi_dec = humi_dec;
    assign if2.temp_int = temp_int; assign if2.temp_dec = temp_dec;
    assign if2.bad_crc  = bad_crc;

    dht11_sensor_emu #(.CLK_PER_US(1), .START_MIN_US(START_MIN)) u0 (
        .clk(clk), .rst_n(rst_n), .dht11(line0), .bus(if0));
    dht11_sensor_emu #(.CLK_PER_US(2), .START_MIN_US(START_MIN)) u1 (
        .clk(clk), .rst_n(rst_n), .dht11(line1), .bus(if1));
    dht11_sensor_emu #(.CLK_PER_US(27), .START_MIN_US(START_MIN)) u2 (
        .clk(clk), .rst_n(rst_n), .dht11(line2), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic line_of(input int s);
        return (s == 0) ? line0 : (s == 1) ? line1 : line2;
    endfunction
    function automatic logic busy_of(input int s);
        return (s == 0) ? if0.busy : (s == 1) ? if1.busy : if2.busy;
    endfunction
    function automatic logic done_of(input int s);
        return (s == 0) ? if0.frame_done : (s == 1) ? if1.frame_done : if2.frame_done;
    endfunction
    function automatic logic coll_of(input int s);
        return (s == 0) ? if0.collision : (s == 1) ? if1.collision : if2.collision;
    endfunction

    // Reference frame from the protocol rules: bytes, then the sum mod 256,
    // complemented when the checksum fault is injected.
    function automatic logic [39:0] model_frame(input int h, input int hd, input int t,
                                                input int td, input bit bad);
        int s;
        s = (h + hd + t + td) % 256;
        if (bad) s = 255 - s;
        return {8'(h), 8'(hd), 8'(t), 8'(td), 8'(s)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_w(input string tag, input int w, input int exp);
        n_assert++;
        assert ((w >= exp - 1) && (w <= exp + 1))
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d clk expected=%0d clk (+-1)", tag, w, exp);
        end
    endtask

    task automatic wait_level(input int sel, input logic lvl, input int budget,
                              output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (!ok && n <= budget) begin
            @(negedge clk);
            if (line_of(sel) === lvl) ok = 1'b1;
            else                      n++;
        end
    endtask

    task automatic host_start(input int sel, input int cpu, input int us);
        @(negedge clk);
        host_low[sel] = 1'b1;
        repeat (us * cpu) @(negedge clk);
        host_low[sel] = 1'b0;
    endtask

    task automatic do_frame(input int sel, input int cpu, input int chg_bit,
                            input logic [7:0] chg_val, input bit partial,
                            output logic [39:0] bits);
        int         n;
        bit         ok;
        bit         all_ok;
        logic [39:0] b;
        b      = '0;
        all_ok = 1'b1;
        host_start(sel, cpu, START_US);
        wait_level(sel, 1'b0, 60 * cpu + 20, n, ok);
        check("resp_seen", ok, 1);
        n_assert++;
        assert ((n >= 30 * cpu) && (n <= 30 * cpu + 4))
        else begin
            n_fail++;
            $error("FAIL resp_delay observed=%0d clk expected=%0d..%0d clk", n, 30 * cpu, 30 * cpu + 4);
        end
        check("busy_in_frame", busy_of(sel), 1);
        wait_level(sel, 1'b1, 100 * cpu + 20, n, ok);
        all_ok &= ok;
        check_w("resp_low", n + 1, 80 * cpu);
        wait_level(sel, 1'b0, 100 * cpu + 20, n, ok);
        all_ok &= ok;
        check_w("resp_high", n + 1, 80 * cpu);
        for (int i = 39; i >= 0; i--) begin
            wait_level(sel, 1'b1, 100 * cpu + 20, n, ok);
            all_ok &= ok;
            if (i == 39) check_w("bit_low", n + 1, 50 * cpu);
            if (i == chg_bit) humi_int = chg_val;
            if (partial) begin
                check("phase_timeouts", all_ok, 1);
                bits = '0;
                return;
            end
            wait_level(sel, 1'b0, 100 * cpu + 20, n, ok);
            all_ok &= ok;
            b[i] = ((n + 1) > 48 * cpu);
            if (i == 39) check_w("bit39_high", n + 1, (b[i] ? 70 : 26) * cpu);
        end
        wait_level(sel, 1'b1, 100 * cpu + 20, n, ok);
        all_ok &= ok;
        check("phase_timeouts", all_ok, 1);
        check_w("end_low", n + 1, 50 * cpu);
        check("frame_done_at_release", done_of(sel), 1);
        check("busy_after_frame", busy_of(sel), 0);
        @(negedge clk);
        check("frame_done_one_clk", done_of(sel), 0);
        bits = b;
    endtask

    initial begin : main
        logic [39:0] got;
        int          n, cc, dn, lows, bsy;
        bit          ok;
        int          h, hd, t, td;
        bit          bad;

        n_assert = 0;
        n_fail   = 0;
        host_low = 3'b000;
        humi_int = 8'd45; humi_dec = 8'd0; temp_int = 8'd23; temp_dec = 8'd5;
        bad_crc  = 1'b0;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_line", line0, 1);
        check("rst_busy", if0.busy, 0);
        check("rst_done", if0.frame_done, 0);
        check("rst_coll", if0.collision, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Nominal frame
        do_frame(0, 1, -1, 8'd0, 1'b0, got);
        check("frame_nominal", got, 40'h2D_00_17_05_49);
        check("frame_nominal_model", got, model_frame(45, 0, 23, 5, 1'b0));
        repeat (20) @(negedge clk);

        // Checksum fault injection
        bad_crc = 1'b1;
        do_frame(0, 1, -1, 8'd0, 1'b0, got);
        check("crc_byte_bad", got[7:0], 8'hB6);
        check("crc_bad_rejected", (got[7:0] == 8'(got[39:32] + got[31:24] + got[23:16] + got[15:8])), 0);
        bad_crc = 1'b0;
        repeat (20) @(negedge clk);

        // Short host pulse: no response
        host_start(0, 1, 50);
        lows = 0; bsy = 0;
        repeat (300) begin
            @(negedge clk);
            if (line0 !== 1'b1) lows++;
            if (if0.busy) bsy++;
        end
        check("short_no_resp", lows, 0);
        check("short_no_busy", bsy, 0);

        // Collision 20 us into bit 39 high
        host_start(0, 1, START_US);
        wait_level(0, 1'b0, 100, n, ok);
        wait_level(0, 1'b1, 120, n, ok);
        wait_level(0, 1'b0, 120, n, ok);
        wait_level(0, 1'b1, 120, n, ok);
        check("coll_reach_bit39", ok, 1);
        repeat (19) @(negedge clk);
        host_low[0] = 1'b1;
        cc = 0; dn = 0;
        repeat (20) begin
            @(negedge clk);
            cc += int'(if0.collision);
            dn += int'(if0.frame_done);
        end
        check("coll_pulse_once", cc, 1);
        check("coll_no_done", dn, 0);
        check("coll_busy", if0.busy, 0);
        host_low[0] = 1'b0;
        repeat (300) @(negedge clk);
        check("coll_idle_busy", if0.busy, 0);
        do_frame(0, 1, -1, 8'd0, 1'b0, got);
        check("frame_after_coll", got, model_frame(45, 0, 23, 5, 1'b0));
        repeat (20) @(negedge clk);

        // Input change mid-frame
        do_frame(0, 1, 20, 8'd99, 1'b0, got);
        check("frame_latched", got, model_frame(45, 0, 23, 5, 1'b0));
        repeat (20) @(negedge clk);
        do_frame(0, 1, -1, 8'd0, 1'b0, got);
        check("frame_new_value", got, model_frame(99, 0, 23, 5, 1'b0));
        humi_int = 8'd45;
        repeat (20) @(negedge clk);

        // Reset during BIT_LOW
        host_start(0, 1, START_US);
        wait_level(0, 1'b0, 100, n, ok);
        wait_level(0, 1'b1, 120, n, ok);
        wait_level(0, 1'b0, 120, n, ok);
        check("rst_mid_reach", ok, 1);
        repeat (10) @(negedge clk);
        check("rst_mid_driving", line0, 0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_released", line0, 1);
        check("rst_mid_busy", if0.busy, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        do_frame(0, 1, -1, 8'd0, 1'b0, got);
        check("frame_after_rst", got, model_frame(45, 0, 23, 5, 1'b0));

        // Random payloads
        for (int k = 0; k < 3; k++) begin
            h = int'($urandom_range(255)); hd = int'($urandom_range(255));
            t = int'($urandom_range(255)); td = int'($urandom_range(255));
            bad = 1'($urandom_range(1));
            humi_int = 8'(h); humi_dec = 8'(hd); temp_int = 8'(t); temp_dec = 8'(td);
            bad_crc = bad;
            repeat (20) @(negedge clk);
            do_frame(0, 1, -1, 8'd0, 1'b0, got);
            check("frame_random", got, model_frame(h, hd, t, td, bad));
        end
        bad_crc = 1'b0;

        // Prescale sweep
        do_frame(1, 2, -1, 8'd0, 1'b0, got);
        check("frame_cpu2", got, model_frame(int'(humi_int), int'(humi_dec),
                                             int'(temp_int), int'(temp_dec), 1'b0));
        do_frame(2, 27, -1, 8'd0, 1'b1, got);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
